// File: rtl/dsp_pkg.sv
// dsp_pkg: definitions shared by the DSP core and its instruction sequencer.
//   OPCODE_WIDTH / INSTR_WIDTH : instruction word layout (opcode 6 + two 10-bit addrs)
//   PROG_ADDR_WIDTH            : program memory address width
//   PIPE_DEPTH                 : core stages after issue; must track the core's stage count
//   FRAME_CNT_WIDTH            : width of the completed-frame counter
//   NOP_INSTR                  : all-zero word, opcode 6'h00
//   seq_state_t                : sequencer states IDLE / RUN / DRAIN
package dsp_pkg;

  localparam int OPCODE_WIDTH    = 6;
  localparam int INSTR_WIDTH     = 26;
  localparam int PROG_ADDR_WIDTH = 10;
  localparam int PIPE_DEPTH      = 4;
  localparam int FRAME_CNT_WIDTH = 16;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/dsp_sequencer_if.sv
// dsp_sequencer_if: read port of the external program memory (registered
// address, one-cycle read latency).
//   prog_rd_addr : read address      (master -> slave)
//   prog_rd_en   : read enable       (master -> slave)
//   prog_rd_data : read data, valid one cycle after addr/en (slave -> master)
// Modports: master = sequencer, slave = program memory.
interface dsp_sequencer_if #(
  parameter int INSTR_WIDTH     = 26,
  parameter int PROG_ADDR_WIDTH = 10
);

  logic [PROG_ADDR_WIDTH-1:0] prog_rd_addr;
  logic                       prog_rd_en;
  logic [INSTR_WIDTH-1:0]     prog_rd_data;

  modport master (
    output prog_rd_addr,
    output prog_rd_en,
    input  prog_rd_data
  );

  modport slave (
    input  prog_rd_addr,
    input  prog_rd_en,
    output prog_rd_data
  );

endinterface

// File: rtl/dsp_sequencer.sv
// dsp_sequencer: issues one program per audio frame to a DSP core.
// On an accepted frame_sync it reads words 0..prog_last from program memory,
// one per clock, presents them on instruction (NOP otherwise), waits
// PIPE_DEPTH+1 cycles for the core pipeline to drain and pulses frame_done.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   enable           : gates acceptance of frame_sync in IDLE
//   frame_sync       : single-cycle frame start pulse
//   prog_last        : last program address, latched at frame start
//   prog             : program memory read port (master side)
//   instruction      : instruction to the core, NOP when not issuing
//   busy             : high in RUN or DRAIN
//   frame_done       : one-cycle pulse after drain
//   overrun          : sticky, set by frame_sync while busy
//   overrun_clr      : clears overrun (a simultaneous set wins)
//   frame_count      : completed frames, wrapping
module dsp_sequencer #(
  parameter int INSTR_WIDTH     = dsp_pkg::INSTR_WIDTH,
  parameter int PROG_ADDR_WIDTH = dsp_pkg::PROG_ADDR_WIDTH,
  parameter int PIPE_DEPTH      = dsp_pkg::PIPE_DEPTH,
  parameter int FRAME_CNT_WIDTH = dsp_pkg::FRAME_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       frame_sync,
  input  logic [PROG_ADDR_WIDTH-1:0] prog_last,
  dsp_sequencer_if.master            prog,
  output logic [INSTR_WIDTH-1:0]     instruction,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun,
  input  logic                       overrun_clr,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

  import dsp_pkg::*;

  localparam int DRAIN_W = $clog2(PIPE_DEPTH + 1);

  seq_state_t                 state_q, state_d;
  logic [PROG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PROG_ADDR_WIDTH-1:0] last_q, last_d;
  logic [DRAIN_W-1:0]         drain_q, drain_d;
  logic                       rd_valid_q;
  logic                       frame_done_q, frame_done_d;
  logic                       overrun_q, overrun_d;
  logic [FRAME_CNT_WIDTH-1:0] fcnt_q, fcnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      last_q       <= '0;
      drain_q      <= '0;
      rd_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      fcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      last_q       <= last_d;
      drain_q      <= drain_d;
      // Memory data lags the read request by one cycle; track which cycles carry it.
      rd_valid_q   <= prog.prog_rd_en;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      fcnt_q       <= fcnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    last_d       = last_q;
    drain_d      = drain_q;
    frame_done_d = 1'b0;
    fcnt_d       = fcnt_q;
    overrun_d    = overrun_q;

    unique case (state_q)
      IDLE: begin
        if (frame_sync && enable) begin
          state_d = RUN;
          addr_d  = '0;
          last_d  = prog_last;
        end
      end
      RUN: begin
        if (addr_q == last_q) begin
          state_d = DRAIN;
          drain_d = PIPE_DEPTH[DRAIN_W-1:0];
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        // Counting PIPE_DEPTH down to 0 covers the last instruction's
        // issue cycle plus every core stage behind it.
        if (drain_q == '0) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
          fcnt_d       = fcnt_q + 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A late frame_sync is never lost silently: set has priority over clear.
    if (frame_sync && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  assign prog.prog_rd_en   = (state_q == RUN);
  assign prog.prog_rd_addr = addr_q;

  // Combinational from the memory output register so issue adds no latency.
  assign instruction = rd_valid_q ? prog.prog_rd_data : NOP_INSTR;
  assign busy        = (state_q != IDLE);
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_dsp_sequencer.sv
// tb_dsp_sequencer: directed plus randomized bench for dsp_sequencer with a
// cycle-indexed reference model of frame timing and a behavioural program memory.
module tb_dsp_sequencer;

  localparam int IW  = 26;
  localparam int AW  = 10;
  localparam int PD  = 4;
  localparam int CW  = 16;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          frame_sync;
  logic [AW-1:0] prog_last;
  logic          overrun_clr;
  logic [IW-1:0] instruction;
  logic          busy;
  logic          frame_done;
  logic          overrun;
  logic [CW-1:0] frame_count;

  dsp_sequencer_if #(.INSTR_WIDTH(IW), .PROG_ADDR_WIDTH(AW)) bus ();

  dsp_sequencer #(
    .INSTR_WIDTH(IW), .PROG_ADDR_WIDTH(AW), .PIPE_DEPTH(PD), .FRAME_CNT_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .frame_sync  (frame_sync),
    .prog_last   (prog_last),
    .prog        (bus.master),
    .instruction (instruction),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  // Program memory: registered address, one-cycle latency.
  logic [IW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.prog_rd_en) bus.prog_rd_data <= mem[bus.prog_rd_addr];
  end

  // Reference model: expectations laid out per cycle from the frame timing rules.
  bit [IW-1:0] exp_instr [0:MAXC-1];
  bit          exp_done  [0:MAXC-1];
  int          cyc;
  int          busy_lo, free_at, run_lo, run_hi;
  logic        m_ov;
  logic [CW-1:0] m_cnt;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_cycle();
    bit exp_busy, exp_en;
    if (exp_done[cyc]) m_cnt = m_cnt + 1'b1;
    exp_busy = (cyc >= busy_lo) && (cyc < free_at);
    exp_en   = (cyc >= run_lo) && (cyc <= run_hi);
    chk("instruction", 32'(instruction), 32'(exp_instr[cyc]));
    chk("frame_done",  32'(frame_done),  32'(exp_done[cyc]));
    chk("busy",        32'(busy),        32'(exp_busy));
    chk("prog_rd_en",  32'(bus.prog_rd_en), 32'(exp_en));
    if (exp_en) chk("prog_rd_addr", 32'(bus.prog_rd_addr), 32'(cyc - run_lo));
    chk("overrun",     32'(overrun),     32'(m_ov));
    chk("frame_count", 32'(frame_count), 32'(m_cnt));
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model, clock.
  task automatic tick(input bit fs, input bit en, input bit clr, input int last);
    bit busy_now;
    check_cycle();
    frame_sync  = fs;
    enable      = en;
    overrun_clr = clr;
    prog_last   = AW'(last);
    busy_now = (cyc >= busy_lo) && (cyc < free_at);
    if (fs && !busy_now && en) begin
      run_lo  = cyc + 1;
      run_hi  = cyc + 1 + last;
      busy_lo = cyc + 1;
      free_at = cyc + 3 + last + PD;
      for (int i = 0; i <= last; i++) exp_instr[cyc + 2 + i] = mem[i];
      exp_done[free_at] = 1'b1;
    end
    if (fs && busy_now)  m_ov = 1'b1;
    else if (clr)        m_ov = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) tick(1'b0, en, 1'b0, int'($urandom_range(0, 15)));
  endtask

  // Reset asserted in the middle of the current cycle.
  task automatic mid_reset();
    check_cycle();
    frame_sync  = 1'b0;
    overrun_clr = 1'b0;
    reset_n     = 1'b0;
    #1;
    chk("rst_instruction", 32'(instruction), 32'h0);
    chk("rst_busy",        32'(busy),        32'h0);
    chk("rst_frame_count", 32'(frame_count), 32'h0);
    chk("rst_prog_rd_en",  32'(bus.prog_rd_en), 32'h0);
    chk("rst_overrun",     32'(overrun),     32'h0);
    for (int k = cyc; k < MAXC; k++) begin
      exp_instr[k] = '0;
      exp_done[k]  = 1'b0;
    end
    busy_lo = 0; free_at = 0; run_lo = 1; run_hi = 0;
    m_ov = 1'b0; m_cnt = '0;
    @(posedge clk);
    #1;
    cyc++;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; frame_sync = 1'b0;
    overrun_clr = 1'b0; prog_last = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = IW'($urandom);
    cyc = 0; busy_lo = 0; free_at = 0; run_lo = 1; run_hi = 0;
    m_ov = 1'b0; m_cnt = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_instruction", 32'(instruction), 32'h0);
    chk("reset_busy",        32'(busy),        32'h0);
    chk("reset_frame_done",  32'(frame_done),  32'h0);
    chk("reset_overrun",     32'(overrun),     32'h0);
    chk("reset_frame_count", 32'(frame_count), 32'h0);
    chk("reset_prog_rd_en",  32'(bus.prog_rd_en), 32'h0);
    chk("reset_prog_rd_addr", 32'(bus.prog_rd_addr), 32'h0);
    reset_n = 1'b1;
    idle(2, 1'b1);

    // Four-word frame, prog_last wandering while it runs.
    tick(1'b1, 1'b1, 1'b0, 3);
    idle(12, 1'b1);

    // Single-instruction frame.
    tick(1'b1, 1'b1, 1'b0, 0);
    idle(9, 1'b1);

    // Overrun at t+4, then clear, then clear colliding with a busy frame_sync.
    tick(1'b1, 1'b1, 1'b0, 3);
    idle(3, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 7);
    idle(8, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 0);
    idle(1, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 3);
    idle(2, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 3);
    idle(10, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 0);

    // Back-to-back frames: next frame_sync lands on the frame_done cycle.
    tick(1'b1, 1'b1, 1'b0, 2);
    while (cyc < free_at) tick(1'b0, 1'b1, 1'b0, 9);
    tick(1'b1, 1'b1, 1'b0, 5);
    while (cyc < free_at) tick(1'b0, 1'b1, 1'b0, 1);
    idle(2, 1'b1);

    // Disabled frame_sync is ignored; enable dropped mid-frame is harmless.
    tick(1'b1, 1'b0, 1'b0, 3);
    idle(4, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 3);
    idle(2, 1'b1);
    idle(12, 1'b0);

    // Reset mid-frame at t+3, then a fresh frame from address 0.
    tick(1'b1, 1'b1, 1'b0, 3);
    idle(2, 1'b1);
    mid_reset();
    tick(1'b1, 1'b1, 1'b0, 2);
    idle(10, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 15) == 0), int'($urandom_range(0, 7)));
    end
    idle(16, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dsp_sequencer.md
# dsp_sequencer

Instruction sequencer driving the `instruction` input of one DSP core. Once per audio frame (`frame_sync`), it reads a program of `prog_last+1` words from an external program memory and presents one instruction per clock. It inserts NOPs at all other times, waits for the core pipeline to drain, then signals `frame_done` so downstream IO logic can swap buffers. It also flags frame overruns and counts completed frames.

## Interface
- `INSTR_WIDTH`, 26: instruction word width (opcode 6 + sample addr 10 + param addr 10).
- `PROG_ADDR_WIDTH`, 10: program memory address width.
- `PIPE_DEPTH`, 4: core stages after issue (read, ex1, ex2, writeback) that must drain before `frame_done`.
- `FRAME_CNT_WIDTH`, 16: width of `frame_count`.
- `clk`, in, 1: clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: when 0, frame starts are ignored.
- `frame_sync`, in, 1: single-cycle frame start pulse, synchronous to `clk`.
- `prog_last`, in, `PROG_ADDR_WIDTH`: address of the last program word; latched at frame start.
- `prog_rd_addr`, out, `PROG_ADDR_WIDTH`: program memory read address.
- `prog_rd_en`, out, 1: program memory read enable.
- `prog_rd_data`, in, `INSTR_WIDTH`: program memory data, valid 1 cycle after address/enable.
- `instruction`, out, `INSTR_WIDTH`: instruction to the core. All-zero (NOP, opcode 6'h00) when not issuing.
- `busy`, out, 1: high while in RUN or DRAIN.
- `frame_done`, out, 1: one-cycle pulse after the pipeline has drained.
- `overrun`, out, 1: sticky flag, set when `frame_sync` arrives while busy.
- `overrun_clr`, in, 1: clears `overrun`.
- `frame_count`, out, `FRAME_CNT_WIDTH`: completed frames, wraps modulo 2^`FRAME_CNT_WIDTH`.

## Operation
- States: IDLE, RUN, DRAIN. Reset state is IDLE.
- Reset values: `prog_rd_addr` 0, `prog_rd_en` 0, `instruction` 0, `busy` 0, `frame_done` 0, `overrun` 0, `frame_count` 0. Internal valid pipe and drain counter are cleared.
- IDLE → RUN: requires `frame_sync` and `enable` both high.
  - Latch `prog_last` into `last_q`.
  - Address counter is set to 0.
- RUN: drive `prog_rd_en`=1 and `prog_rd_addr`=counter. The counter increments each cycle.
  - When counter == `last_q`, go to DRAIN and load the drain counter with `PIPE_DEPTH`.
- Issue valid: `rd_valid` is `prog_rd_en` delayed by 1 cycle. `instruction` = `rd_valid` ? `prog_rd_data` : 0.
  - `instruction` is combinational from the memory output register; no extra register.
- DRAIN: `prog_rd_en`=0. The drain counter decrements each cycle.
  - At 0, go to IDLE and register `frame_done`=1 for exactly one cycle.
  - `frame_count` increments on that same edge.
- `prog_last` = 0 is legal: a one-instruction frame.
- `frame_sync` in RUN or DRAIN: ignored for sequencing; sets `overrun`. If `overrun_clr` is high in the same cycle, set wins.
- `frame_sync` in the `frame_done` cycle: the state is already IDLE, so the frame is accepted with no overrun.
- `frame_sync` in IDLE with `enable`=0: ignored, no overrun.
- `enable` deasserted mid-frame: the current frame completes normally.
- `prog_last` changed mid-frame: no effect until the next frame start.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously). `instruction` becomes NOP the same cycle.

## Timing
- `frame_sync` high in cycle t (IDLE):
  - t+1: RUN, `prog_rd_addr`=0, `prog_rd_en`=1, `busy`=1.
  - t+2: `instruction`=mem[0].
- Throughput: one instruction per cycle, with no gaps within a frame.
- Last address `last_q` is issued at cycle t+1+`last_q`. `instruction`=mem[`last_q`] at t+2+`last_q`.
- DRAIN spans cycles t+2+`last_q` through t+2+`last_q`+`PIPE_DEPTH`.
- `frame_done`=1 and `busy`=0 at t+3+`last_q`+`PIPE_DEPTH`.
- Minimum frame period without overrun: `last_q`+`PIPE_DEPTH`+3 cycles.

## Structure
- Shared `dsp_pkg` holds:
  - `OPCODE_WIDTH`, `INSTR_WIDTH`, `NOP_INSTR` ('0).
  - `PIPE_DEPTH`, which must track the core's stage count.
  - `seq_state_t` enum: IDLE, RUN, DRAIN.
- No sub-module is natural. The program memory is an external altsyncram (registered address, 1-cycle latency) instantiated alongside the core.

## Test plan
- Reset, then `frame_sync` with `prog_last`=3 and mem={A,B,C,D}:
  - `instruction` = A,B,C,D at t+2..t+5, NOP otherwise.
  - `frame_done` at t+10; `frame_count`=1.
- `prog_last`=0: single instruction at t+2; `frame_done` at t+7.
- `frame_sync` at t+4 during a `prog_last`=3 frame:
  - `overrun`=1; the frame is unaltered; no second frame starts.
  - Pulse `overrun_clr` → `overrun`=0. `overrun_clr` and `frame_sync` in the same busy cycle → `overrun`=1.
- Back-to-back frames with `frame_sync` on the `frame_done` cycle: a new frame starts, no overrun, no NOP gap beyond the drain.
- `enable`=0 with `frame_sync` → nothing issued, `busy`=0. `enable` dropped at t+3 → the frame completes.
- `reset_n` pulled low at t+3 mid-frame: `instruction`=0, `busy`=0, `frame_count`=0 immediately. After release, the next `frame_sync` starts from address 0.
